// File: rtl/button_conditioner_pkg.sv
// button_conditioner_pkg: shared channel indices, repeat FSM states and counter sizing helpers
package button_conditioner_pkg;
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_U = 2;
  localparam int BTN_D = 3;
  localparam int NUM_BTNS_DEFAULT = 4;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_e;
  function automatic int max_int(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/button_conditioner_channel.sv
// button_conditioner_channel: sync, debounce and auto-repeat for one button
module button_conditioner_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int REPEAT_DELAY_CYCLES = 20_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 2_500_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic btn_raw_in,
  input  logic repeat_en_in,
  output logic level_out,
  output logic press_out,
  output logic release_out
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(max_int(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
  localparam logic [DW-1:0] DEB_MAX = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_MAX = RW'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [RW-1:0] PER_MAX = RW'(REPEAT_PERIOD_CYCLES - 1);
  logic sync1, sync2, flip, rise, fall, rep_hit;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  rep_state_e state;
  always_comb begin
    flip = sync2 != level_out && dcnt == DEB_MAX;
    rise = flip & sync2;
    fall = flip & ~sync2;
    rep_hit = repeat_en_in && (state == DELAY ? rcnt == DLY_MAX : state == REPEAT && rcnt == PER_MAX);
  end
  // a debounced fall always beats a repeat pulse landing on the same edge
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dcnt <= '0;
      level_out <= 1'b0;
      press_out <= 1'b0;
      release_out <= 1'b0;
      state <= IDLE;
      rcnt <= '0;
    end else begin
      sync1 <= btn_raw_in;
      sync2 <= sync1;
      dcnt <= (sync2 == level_out || flip) ? '0 : dcnt + 1'b1;
      if (flip) level_out <= sync2;
      press_out <= rise | (rep_hit & ~fall);
      release_out <= fall;
      if (fall) begin
        state <= IDLE;
        rcnt <= '0;
      end else if (rise || (state != IDLE && !repeat_en_in)) begin
        state <= DELAY;
        rcnt <= '0;
      end else if (rep_hit) begin
        state <= REPEAT;
        rcnt <= '0;
      end else if (state != IDLE) rcnt <= rcnt + 1'b1;
    end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: independent debounced level/press/release channels for the board pushbuttons
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int NUM_BTNS = NUM_BTNS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int REPEAT_DELAY_CYCLES = 20_000_000,
  parameter int REPEAT_PERIOD_CYCLES = 2_500_000
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [NUM_BTNS-1:0] btn_raw_in,
  input  logic                repeat_en_in,
  output logic [NUM_BTNS-1:0] btn_level_out,
  output logic [NUM_BTNS-1:0] btn_press_out,
  output logic [NUM_BTNS-1:0] btn_release_out
);
  genvar i;
  for (i = 0; i < NUM_BTNS; i++) begin : g_ch
    button_conditioner_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
    ) u_ch (
      .clk_in(clk_in),
      .rst_n_in(rst_n_in),
      .btn_raw_in(btn_raw_in[i]),
      .repeat_en_in(repeat_en_in),
      .level_out(btn_level_out[i]),
      .press_out(btn_press_out[i]),
      .release_out(btn_release_out[i])
    );
  end
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: table vectors, corner sequences and random stimulus against a reference model
module tb_button_conditioner;
  import button_conditioner_pkg::*;
  localparam int D = 4;
  localparam int RD = 10;
  localparam int RP = 3;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic [3:0] btn_raw_in = '0;
  logic repeat_en_in = 1'b1;
  logic [3:0] btn_level_out, btn_press_out, btn_release_out;
  int errors = 0;
  int checks = 0;
  int pc, rc, cyc_n;
  logic [3:0] lvl_acc;
  logic [3:0] m_s1, m_s2, m_lvl, m_press, m_rel;
  int m_dis[4];
  int m_age[4];
  bit m_first[4];
  typedef struct {
    logic [3:0] raw;
    logic en;
    int cyc;
    logic [3:0] lvl;
    int np;
    int nr;
  } vec_t;
  vec_t tbl[12];

  button_conditioner #(
    .NUM_BTNS(4),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RD),
    .REPEAT_PERIOD_CYCLES(RP)
  ) dut (
    .clk_in(clk_in),
    .rst_n_in(rst_n_in),
    .btn_raw_in(btn_raw_in),
    .repeat_en_in(repeat_en_in),
    .btn_level_out(btn_level_out),
    .btn_press_out(btn_press_out),
    .btn_release_out(btn_release_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    m_lvl = '0;
    m_press = '0;
    m_rel = '0;
    for (int c = 0; c < 4; c++) begin
      m_dis[c] = 0;
      m_age[c] = 0;
      m_first[c] = 1'b1;
    end
  endtask

  // level flips after D consecutive edges of disagreement; repeats are measured as age since the last anchor
  task automatic model_step();
    for (int c = 0; c < 4; c++) begin
      m_press[c] = 1'b0;
      m_rel[c] = 1'b0;
      m_dis[c] = (m_s2[c] != m_lvl[c]) ? m_dis[c] + 1 : 0;
      if (m_dis[c] == D) begin
        m_dis[c] = 0;
        m_lvl[c] = m_s2[c];
        m_press[c] = m_s2[c];
        m_rel[c] = ~m_s2[c];
        m_age[c] = 0;
        m_first[c] = 1'b1;
      end else if (m_lvl[c]) begin
        if (!repeat_en_in) begin
          m_age[c] = 0;
          m_first[c] = 1'b1;
        end else begin
          m_age[c]++;
          if (m_age[c] == (m_first[c] ? RD : RP)) begin
            m_press[c] = 1'b1;
            m_age[c] = 0;
            m_first[c] = 1'b0;
          end
        end
      end
    end
    m_s2 = m_s1;
    m_s1 = btn_raw_in;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk_in);
    if (rst_n_in) model_step();
    else model_reset();
    @(negedge clk_in);
    cyc_n++;
    checks++;
    if ({btn_level_out, btn_press_out, btn_release_out} != {m_lvl, m_press, m_rel}) begin
      errors++;
      $display("FAIL model cyc%0d: got lvl=%b prs=%b rel=%b expected lvl=%b prs=%b rel=%b", cyc_n,
               btn_level_out, btn_press_out, btn_release_out, m_lvl, m_press, m_rel);
    end
    pc += $countones(btn_press_out);
    rc += $countones(btn_release_out);
    lvl_acc |= btn_level_out;
  endtask

  initial begin
    tbl[0]  = '{4'b0001, 1'b1, 5,  4'b0000, 0, 0};
    tbl[1]  = '{4'b0001, 1'b1, 1,  4'b0001, 1, 0};
    tbl[2]  = '{4'b0001, 1'b1, 10, 4'b0001, 1, 0};
    tbl[3]  = '{4'b0001, 1'b1, 6,  4'b0001, 2, 0};
    tbl[4]  = '{4'b0000, 1'b1, 3,  4'b0001, 1, 0};
    tbl[5]  = '{4'b0000, 1'b1, 4,  4'b0000, 0, 1};
    tbl[6]  = '{4'b0110, 1'b0, 30, 4'b0110, 2, 0};
    tbl[7]  = '{4'b0110, 1'b1, 10, 4'b0110, 2, 0};
    tbl[8]  = '{4'b0100, 1'b1, 8,  4'b0100, 3, 1};
    tbl[9]  = '{4'b1100, 1'b1, 3,  4'b0100, 1, 0};
    tbl[10] = '{4'b0100, 1'b1, 5,  4'b0100, 2, 0};
    tbl[11] = '{4'b0000, 1'b1, 8,  4'b0000, 2, 1};
    cyc_n = 0;
    model_reset();
    for (int k = 0; k < 3; k++) cycle();
    rst_n_in = 1'b1;
    for (int t = 0; t < 12; t++) begin
      btn_raw_in = tbl[t].raw;
      repeat_en_in = tbl[t].en;
      pc = 0;
      rc = 0;
      for (int k = 0; k < tbl[t].cyc; k++) cycle();
      chk($sformatf("vec%0d level", t), int'(btn_level_out), int'(tbl[t].lvl));
      chk($sformatf("vec%0d presses", t), pc, tbl[t].np);
      chk($sformatf("vec%0d releases", t), rc, tbl[t].nr);
    end
    pc = 0;
    rc = 0;
    lvl_acc = '0;
    for (int r = 0; r < 5; r++) begin
      btn_raw_in[BTN_U] = 1'b1;
      for (int k = 0; k < 3; k++) cycle();
      btn_raw_in[BTN_U] = 1'b0;
      cycle();
    end
    for (int k = 0; k < 6; k++) cycle();
    chk("glitch level", int'(lvl_acc), 0);
    chk("glitch presses", pc, 0);
    chk("glitch releases", rc, 0);
    btn_raw_in = 4'b0001;
    repeat_en_in = 1'b1;
    for (int k = 0; k < 12; k++) cycle();
    chk("hold level before reset", int'(btn_level_out[BTN_L]), 1);
    @(posedge clk_in);
    model_step();
    #2 rst_n_in = 1'b0;
    model_reset();
    #1;
    chk("async reset outputs", int'({btn_level_out, btn_press_out, btn_release_out}), 0);
    for (int k = 0; k < 2; k++) cycle();
    rst_n_in = 1'b1;
    pc = 0;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      if (k == 5) chk("post-reset level edge5", int'(btn_level_out[BTN_L]), 0);
    end
    chk("post-reset level edge6", int'(btn_level_out[BTN_L]), 1);
    chk("post-reset press edge6", int'(btn_press_out[BTN_L]), 1);
    chk("post-reset press count", pc, 1);
    for (int k = 0; k < 2500; k++) begin
      if ($urandom_range(0, 7) == 0) btn_raw_in[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) repeat_en_in = ~repeat_en_in;
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front end that produces the button levels consumed by the camera/user-control logic.
- Takes raw asynchronous pushbuttons, synchronizes and debounces each one, then emits clean levels plus single-cycle press, auto-repeat and release pulses.
- Sits between the board pins and all user-input consumers.
- Channels are independent; conflicting-button policy (e.g. left and right together) stays in the consumers.

Parameters:
- NUM_BTNS, 4, number of channels; bit order [0]=L, [1]=R, [2]=U, [3]=D.
- DEBOUNCE_CYCLES, 250_000, cycles of continuous disagreement needed to flip a stable level (5 ms at 20 ns).
- REPEAT_DELAY_CYCLES, 20_000_000, cycles from press pulse to first repeat pulse (400 ms).
- REPEAT_PERIOD_CYCLES, 2_500_000, cycles between subsequent repeat pulses (50 ms).

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- btn_raw_in  input  NUM_BTNS  raw pushbuttons, active high, asynchronous
- repeat_en_in  input  1  global auto-repeat enable
- btn_level_out  output  NUM_BTNS  debounced level
- btn_press_out  output  NUM_BTNS  one-cycle pulse on debounced rise, and on each auto-repeat
- btn_release_out  output  NUM_BTNS  one-cycle pulse on debounced fall

Behaviour:
- Reset: one clock (clk_in); asynchronous, active-low reset on rst_n_in. While rst_n_in=0, all flops clear: sync stages, stable levels, counters, FSMs and all outputs go to 0. Deassertion is synchronized externally.
- Synchronizer: 2-flop per channel (sync1, sync2); raw input is never used combinationally.
- Debounce counter, width $clog2(DEBOUNCE_CYCLES):
  - If sync2==stable, counter <= 0.
  - Else if counter==DEBOUNCE_CYCLES-1, stable <= sync2 and counter <= 0.
  - Else counter increments.
- Latency: raw held high from before edge 0 makes btn_level_out rise after edge DEBOUNCE_CYCLES+1. Any glitch shorter than DEBOUNCE_CYCLES leaves the level unchanged.
- btn_press_out and btn_release_out are registered. They assert on the same edge btn_level_out changes, for exactly one cycle.
- Repeat FSM per channel, states IDLE, DELAY, REPEAT; repeat counter width sized for max(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES).
  - IDLE -> DELAY on debounced rise; counter <= 0.
  - DELAY: counter increments. When counter==REPEAT_DELAY_CYCLES-1, emit press pulse, go to REPEAT, counter <= 0.
  - REPEAT: when counter==REPEAT_PERIOD_CYCLES-1, emit press pulse, counter <= 0.
  - Any state -> IDLE on debounced fall. Release wins: no repeat pulse on the release edge.
- Repeat timing: with the first press pulse at edge P, repeat pulses occur at P+REPEAT_DELAY_CYCLES, then every REPEAT_PERIOD_CYCLES.
- repeat_en_in=0 while held: FSM held in DELAY with counter 0, and no repeat pulses. Re-enabling restarts the full delay.
- Simultaneous buttons: channels are fully independent, so pulses may coincide.
- Reset mid-hold: after release from reset, a still-held button needs the full debounce period again and then produces a fresh press pulse.
- No pulse is produced in the cycle reset releases.

Decomposition:
- types.svh: `BTN_L/`BTN_R/`BTN_U/`BTN_D index macros and `NUM_BTNS.
- Sub-module button_channel: sync + debounce + repeat FSM for one button, outputs level/press/release.
- Top: generate loop of NUM_BTNS instances; repeat_en_in fanned out to all instances.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_PERIOD_CYCLES=3, unless stated otherwise.
1. Raw L high from before edge 0 -> level[0] rises after edge 5; press[0]=1 only during cycle after edge 5; other channels stay 0.
2. Raw U pulses high for 3 cycles, low 1 cycle, repeated 5 times -> level[2], press[2], release[2] never assert.
3. R held with repeat_en_in=1, press at edge P -> press[1] pulses at P, P+10, P+13, P+16. Release -> release[1] single pulse, and no pulse of press[1] on that edge.
4. D held with repeat_en_in=0 for 50 cycles -> exactly one press pulse. Set repeat_en_in=1 at edge Q -> next press pulse at Q+10.
5. L and R rise together, R drops 20 cycles later -> identical press timing on both; only R emits release; L repeats continue.
6. Assert rst_n_in low mid-hold, asynchronously between edges -> all outputs 0 immediately. Deassert with button still high -> level rises exactly 6 edges later, with a fresh press pulse.
